// File: rtl/occ_code_streamer.sv
// occ_code_streamer: captures packed occupancy codes from the BFS core on
// send/finish rising edges, buffers them in a small FIFO and presents them
// as an AXI-Stream master. The word captured on the finish edge carries
// tlast and a tkeep mask covering only the valid tail bytes.
//
// Stream handshake: a word transfers on a rising i_clk edge where
// m_axis_tvalid and m_axis_tready are both high. Once tvalid is high,
// tdata/tlast/tkeep hold steady until that transfer, and tvalid only drops
// after a transfer or on reset. tvalid and every payload output come from
// registered state only. m_axis_tready never reaches an output
// combinationally.
//
// FSM state is visible on o_state (0 = IDLE, 1 = STREAM, 2 = DONE).
module occ_code_streamer #(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [DATA_W-1:0]             i_occ_code,
   input  logic                          i_send,
   input  logic                          i_finish,
   input  logic [15:0]                   i_branch_count,
   output logic [DATA_W-1:0]             m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [DATA_W/8-1:0]           m_axis_tkeep,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow,
   output logic [15:0]                   o_words_sent,
   output logic                          o_done,
   output logic [1:0]                    o_state
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Word buffer storage; contents are only meaningful below the level count.
   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   logic              mem_last [FIFO_DEPTH];
   logic [KEEP_W-1:0] mem_keep [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level;
   logic              send_d, finish_d;
   logic              overflow_q;
   logic [15:0]       words_sent_q;

   logic              send_edge, finish_edge, capture;
   logic              fifo_full, fifo_valid, pop;
   logic              accept, drop, enter_done;
   logic [15:0]       tail_bytes;
   logic [KEEP_W-1:0] keep_in;
   logic              head_last;

   // Edge detection, capture/pop decisions and next-state logic.
   always_comb begin
      send_edge   = i_send & ~send_d;
      finish_edge = i_finish & ~finish_d;
      capture     = send_edge | finish_edge;

      fifo_full   = (level == LVL_W'(FIFO_DEPTH));
      fifo_valid  = (level != '0);
      pop         = fifo_valid & m_axis_tready;
      head_last   = mem_last[rd_ptr];

      // A full buffer still takes a word when the head leaves in the same cycle.
      accept      = capture && (state_q != S_DONE) && (!fifo_full || pop);
      drop        = capture && (state_q != S_DONE) && fifo_full && !pop;

      // Tail mask: n valid bytes packed from the top byte lane downward;
      // a byte count that is a whole number of words means a full word.
      tail_bytes  = i_branch_count % 16'(KEEP_W);
      if (tail_bytes == 16'd0) begin
         keep_in = '1;
      end else begin
         keep_in = ~({KEEP_W{1'b1}} >> tail_bytes);
      end
      if (!finish_edge) begin
         keep_in = '1;
      end

      enter_done  = (state_q == S_STREAM) && pop && head_last;

      state_d     = state_q;
      case (state_q)
         S_IDLE:   if (capture) state_d = S_STREAM;
         S_STREAM: if (enter_done) state_d = S_DONE;
         S_DONE:   state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Pointers and level; entering DONE discards anything captured behind tlast.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (enter_done) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Buffer write; storage is not reset because level gates every read.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         mem_data[wr_ptr] <= i_occ_code;
         mem_last[wr_ptr] <= finish_edge;
         mem_keep[wr_ptr] <= keep_in;
      end
   end

   // Input edge history, sticky overflow and handshake counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         send_d       <= 1'b0;
         finish_d     <= 1'b0;
         overflow_q   <= 1'b0;
         words_sent_q <= '0;
      end else begin
         send_d   <= i_send;
         finish_d <= i_finish;
         if (drop) overflow_q <= 1'b1;
         if (pop)  words_sent_q <= words_sent_q + 16'd1;
      end
   end

   // Stream outputs read the buffer head; payload is zero whenever tvalid is low.
   always_comb begin
      m_axis_tvalid = fifo_valid;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tkeep  = '0;
      if (fifo_valid) begin
         m_axis_tdata = mem_data[rd_ptr];
         m_axis_tlast = head_last;
         m_axis_tkeep = mem_keep[rd_ptr];
      end
   end

   assign o_fifo_level = level;
   assign o_overflow   = overflow_q;
   assign o_words_sent = words_sent_q;
   assign o_done       = (state_q == S_DONE);
   assign o_state      = state_q;

endmodule
